output_spike_buffer: RTL
========================

Name: output_spike_buffer

Overview:
- Sits directly downstream of the grid-edge output bus. Consumes its local output stream (output neuron index plus single-cycle valid) and buffers each spike in a FIFO.
- Tags every spike with the tick index in which it arrived.
- Presents spikes to the host side over a valid/ready stream, so host back-pressure never stalls the router mesh.
- Overflow drops spikes and reports them, instead of back-pressuring.

Parameters:
- NUM_OUTPUTS, 256, number of output neurons; index width OUT_W = $clog2(NUM_OUTPUTS).
- NUM_TICKS, 16, tick tag range; tag width TICK_W = $clog2(NUM_TICKS).
- FIFO_DEPTH, 16, number of buffered entries; must be a power of two and ≥ 2.
- DROP_CNT_W, 16, width of the optional drop counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  single-cycle pulse marking the end of the current tick.
- packet_in  in  OUT_W  output neuron index from the output bus.
- packet_in_valid  in  1  qualifies packet_in for exactly one cycle; it cannot be stalled.
- m_data  out  TICK_W+OUT_W  {tick_tag, neuron_index}, with the tag in the MSBs.
- m_valid  out  1  head entry is available.
- m_ready  in  1  host accepts the head entry.
- fill_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky flag: at least one spike was dropped since the last reset or clear.
- overflow_clr  in  1  clears overflow (and drop_count when the optional feature is built).
- drop_count  out  DROP_CNT_W  present only with OSB_DROP_COUNT_EN.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - tick_tag=0; FIFO pointers=0; fill_level=0; m_valid=0; m_data=0; overflow=0; drop_count=0.
  - Any entries in flight are discarded.
  - Inputs are ignored during the reset cycle.
- Tick counter:
  - tick_tag increments on each tick pulse and wraps from NUM_TICKS-1 to 0.
  - If tick and packet_in_valid are high in the same cycle, the packet takes the pre-increment tag.
- Write: the entry {tick_tag, packet_in} is pushed when packet_in_valid=1 and the write is accepted.
- Read: occurs when m_valid && m_ready; the head pops at that clk edge.
- FIFO mode: first-word fall-through.
  - m_data always shows the head entry while m_valid=1.
  - Latency from a write into an empty FIFO to m_valid=1 is 1 cycle; m_valid rises the cycle after packet_in_valid.
- Full condition:
  - A write is accepted if fill_level < FIFO_DEPTH, OR if fill_level == FIFO_DEPTH and a read occurs in the same cycle.
  - In the second case, occupancy stays at FIFO_DEPTH.
- Empty condition:
  - m_valid=0 and m_ready is ignored.
  - A write into an empty FIFO does not bypass to m_data in the same cycle.
- Simultaneous read and write (not full): fill_level is unchanged.
- Dropped write:
  - packet_in_valid=1 while full and no read → the entry is discarded.
  - overflow is set on the next edge.
- overflow_clr:
  - Clears overflow on the next edge.
  - If a drop occurs in the same cycle, set wins and overflow stays 1.
- Pointers: FIFO_DEPTH-aligned binary pointers with an extra wrap bit; full/empty are derived from pointer comparison.
- fill_level is registered and exact every cycle.
- Stream rule: m_data and m_valid must stay stable while m_valid=1 && m_ready=0.

Optional Feature:
- OSB_DROP_COUNT_EN defined:
  - drop_count increments once per dropped spike and saturates at 2^DROP_CNT_W-1 (no wrap).
  - overflow_clr zeroes it; a simultaneous drop leaves it at 1.
- OSB_DROP_COUNT_EN undefined:
  - The drop_count port and its counter are absent.
  - Only the sticky overflow flag reports loss.

Decomposition:
- Shared package holds:
  - localparams OUT_W and TICK_W;
  - a packed entry typedef {tick_tag, index};
  - a function computing the FIFO level width.
- One natural sub-module: osb_sync_fifo (parameterised width/depth FWFT FIFO with level output).
- The top level owns the tick counter, the drop logic and the overflow/drop counters.

Test Plan:
- Reset then single spike:
  - After rst, packet_in=8'd37 valid for 1 cycle with tick_tag=0 and m_ready=1.
  - Expect m_valid=1 one cycle later with m_data={4'd0,8'd37}; fill_level returns to 0 after the pop.
- Tick tagging:
  - Pulse tick 3 times, then send spike 5 in the same cycle as a 4th tick.
  - Expect m_data={4'd3,8'd5}, and tick_tag=4 afterwards.
- Tick wrap: 16 tick pulses, then spike 200 → m_data={4'd0,8'd200}.
- Fill and overflow:
  - Hold m_ready=0 and send 18 spikes (indices 0..17).
  - Expect fill_level=16 and overflow=1; with the feature built, drop_count=2.
  - Draining yields indices 0..15 in order.
- Full with simultaneous read: at fill_level=16, one cycle with m_ready=1 and spike 99 → no drop, fill_level stays 16, and 99 is the last entry drained.
- Clear versus drop race and reset mid-operation:
  - overflow_clr in the same cycle as a drop → overflow stays 1 (drop_count=1).
  - rst asserted with 5 entries held → m_valid=0 and fill_level=0 on the next cycle.

Source files
------------

// File: rtl/output_spike_buffer_pkg.sv
// rtl/output_spike_buffer_pkg.sv - shared widths, entry layout and level-width helper
package output_spike_buffer_pkg;

  localparam int NUM_OUTPUTS = 256;
  localparam int NUM_TICKS   = 16;
  localparam int OUT_W       = $clog2(NUM_OUTPUTS);
  localparam int TICK_W      = $clog2(NUM_TICKS);

  typedef struct packed {
    logic [TICK_W-1:0] tick_tag;
    logic [OUT_W-1:0]  index;
  } osb_entry_t;

  function automatic int osb_level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/output_spike_buffer_fifo.sv
// rtl/output_spike_buffer_fifo.sv - osb_sync_fifo: first-word fall-through FIFO with exact level
module osb_sync_fifo
  import output_spike_buffer_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic                          rd_en,
  output logic [WIDTH-1:0]              rd_data,
  output logic                          rd_valid,
  output logic                          full,
  output logic [osb_level_w(DEPTH)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = osb_level_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             do_wr;
  logic             do_rd;

  // Extra MSB on each pointer distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/output_spike_buffer.sv
// rtl/output_spike_buffer.sv - tick-tagged spike FIFO with drop reporting; OSB_DROP_COUNT_EN adds drop_count
module output_spike_buffer
  import output_spike_buffer_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DROP_CNT_W = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                tick,
  input  logic [OUT_W-1:0]                    packet_in,
  input  logic                                packet_in_valid,
  output logic [TICK_W+OUT_W-1:0]             m_data,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [osb_level_w(FIFO_DEPTH)-1:0]  fill_level,
  input  logic                                overflow_clr,
`ifdef OSB_DROP_COUNT_EN
  output logic [DROP_CNT_W-1:0]               drop_count,
`endif
  output logic                                overflow
);

  logic [TICK_W-1:0] tick_tag;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;
  osb_entry_t        entry;

  assign entry.tick_tag = tick_tag;
  assign entry.index    = packet_in;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign pop  = m_valid && m_ready;
  assign push = packet_in_valid && (!full || pop);
  assign drop = packet_in_valid && full && !pop;

  osb_sync_fifo #(
    .WIDTH ($bits(osb_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (push),
    .wr_data  (entry),
    .rd_en    (m_ready),
    .rd_data  (m_data),
    .rd_valid (m_valid),
    .full     (full),
    .level    (fill_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_tag <= '0;
    end else if (tick) begin
      tick_tag <= (tick_tag == TICK_W'(NUM_TICKS - 1)) ? '0 : tick_tag + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)               overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

`ifdef OSB_DROP_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
    end else if (overflow_clr) begin
      drop_count <= drop ? DROP_CNT_W'(1) : '0;
    end else if (drop && (drop_count != {DROP_CNT_W{1'b1}})) begin
      drop_count <= drop_count + 1'b1;
    end
  end
`endif

endmodule
